// File: rtl/uart_program_memory.sv
// uart_program_memory: program store loaded byte-by-byte from the UART, read combinationally by fetch.
// Ports:
//   clk, reset (async active-low)
//   run        - leave load mode and start executing
//   reload     - return to load mode, restart the write pointer, keep contents
//   rx_valid   - one-cycle strobe qualifying rx_byte
//   rx_byte    - received byte
//   addr_in    - fetch address
//   insn_out   - fetched word (0 outside execute mode or past DEPTH)
//   read_mode  - high whenever not executing
//   load_count - complete words written since the last load start
//   load_full  - write pointer reached DEPTH (non-wrapping mode only)
//   overflow   - sticky, a byte arrived beyond DEPTH words
//   led        - last byte accepted
module uart_program_memory #(
    parameter int WORD_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int MSB_FIRST  = 1,
    parameter int WRAP       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  reload,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_byte,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    output logic [WORD_WIDTH-1:0] insn_out,
    output logic                  read_mode,
    output logic [ADDR_WIDTH:0]   load_count,
    output logic                  load_full,
    output logic                  overflow,
    output logic [7:0]            led
);
    localparam int BPW = WORD_WIDTH / 8;
    localparam int BW  = BPW > 1 ? $clog2(BPW) : 1;
    localparam int PW  = ADDR_WIDTH + 1;

    typedef enum logic {LOAD, EXEC} state_t;

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] mem_q [DEPTH];
    logic [WORD_WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [BW-1:0]         bcnt_q, bcnt_d;
    logic                  ovf_q, ovf_d;
    logic [7:0]            led_q, led_d;
    logic                  full;
    int                    lane;

    // In wrap mode the pointer never reaches DEPTH, so full only exists without wrap
    assign full = (WRAP == 0) && (wptr_q == PW'(DEPTH));

    always_comb begin
        state_d = state_q;
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        bcnt_d  = bcnt_q;
        ovf_d   = ovf_q;
        led_d   = led_q;
        lane    = MSB_FIRST != 0 ? BPW - 1 - int'(bcnt_q) : int'(bcnt_q);
        if (reload) begin
            state_d = LOAD;
            wptr_d  = '0;
            bcnt_d  = '0;
            ovf_d   = 1'b0;
        end else if (state_q == LOAD) begin
            if (run) begin
                state_d = EXEC;
            end else if (rx_valid) begin
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    for (int i = 0; i < DEPTH; i++)
                        for (int j = 0; j < BPW; j++)
                            if (32'(wptr_q) == i && j == lane)
                                mem_d[i][j*8 +: 8] = rx_byte;
                    led_d = rx_byte;
                    if (int'(bcnt_q) == BPW - 1) begin
                        bcnt_d = '0;
                        if (WRAP != 0 && wptr_q == PW'(DEPTH - 1)) begin
                            wptr_d = '0;
                            ovf_d  = 1'b1;
                        end else begin
                            wptr_d = wptr_q + PW'(1);
                        end
                    end else begin
                        bcnt_d = bcnt_q + BW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LOAD;
            mem_q   <= '{default: '0};
            wptr_q  <= '0;
            bcnt_q  <= '0;
            ovf_q   <= 1'b0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            bcnt_q  <= bcnt_d;
            ovf_q   <= ovf_d;
            led_q   <= led_d;
        end
    end

    // Addresses at or beyond DEPTH match no word and read as 0
    always_comb begin
        insn_out = '0;
        if (state_q == EXEC)
            for (int i = 0; i < DEPTH; i++)
                if (32'(addr_in) == i)
                    insn_out = mem_q[i];
    end

    assign read_mode  = state_q != EXEC;
    assign load_count = wptr_q;
    assign load_full  = full;
    assign overflow   = ovf_q;
    assign led        = led_q;
endmodule

// File: tb/tb_uart_program_memory.sv
// tb_uart_program_memory: directed bench for three configurations of uart_program_memory sharing one stimulus bus.
module tb_uart_program_memory;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        reload = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = '0;
    logic [3:0]  addr_in = '0;

    logic [15:0] insn0, insn2;
    logic [23:0] insn1;
    logic        rm0, rm1, rm2, full0, full1, full2, ovf0, ovf1, ovf2;
    logic [4:0]  cnt0, cnt1, cnt2;
    logic [7:0]  led0, led1, led2;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    uart_program_memory u0 (
        .clk(clk), .reset(reset), .run(run), .reload(reload), .rx_valid(rx_valid),
        .rx_byte(rx_byte), .addr_in(addr_in), .insn_out(insn0), .read_mode(rm0),
        .load_count(cnt0), .load_full(full0), .overflow(ovf0), .led(led0));

    uart_program_memory #(.WORD_WIDTH(24), .MSB_FIRST(0)) u1 (
        .clk(clk), .reset(reset), .run(run), .reload(reload), .rx_valid(rx_valid),
        .rx_byte(rx_byte), .addr_in(addr_in), .insn_out(insn1), .read_mode(rm1),
        .load_count(cnt1), .load_full(full1), .overflow(ovf1), .led(led1));

    uart_program_memory #(.DEPTH(4), .WRAP(1)) u2 (
        .clk(clk), .reset(reset), .run(run), .reload(reload), .rx_valid(rx_valid),
        .rx_byte(rx_byte), .addr_in(addr_in), .insn_out(insn2), .read_mode(rm2),
        .load_count(cnt2), .load_full(full2), .overflow(ovf2), .led(led2));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        addr_in = a;
        #1;
    endtask

    initial begin
        @(negedge clk);
        check("rst_insn", insn0, 0);
        check("rst_read_mode", rm0, 1);
        check("rst_load_count", cnt0, 0);
        check("rst_load_full", full0, 0);
        check("rst_overflow", ovf0, 0);
        check("rst_led", led0, 0);
        reset = 1'b1;
        @(negedge clk);

        // defaults, MSB first
        send(8'h12); send(8'h34); send(8'h56); send(8'h78);
        check("t1_load_count", cnt0, 2);
        check("t1_led", led0, 8'h78);
        pulse_run();
        check("t1_read_mode", rm0, 0);
        rd(0); check("t1_word0", insn0, 16'h1234);
        rd(1); check("t1_word1", insn0, 16'h5678);
        rd(2); check("t1_word2", insn0, 16'h0000);

        // 24-bit words, LSB first, partial second word kept
        do_reset();
        send(8'hAA); send(8'hBB); send(8'hCC);
        check("t2_load_count", cnt1, 1);
        send(8'h11);
        pulse_run();
        rd(0); check("t2_word0", insn1, 24'hCCBBAA);
        rd(1); check("t2_word1", insn1, 24'h000011);

        // fill and overflow without wrap
        do_reset();
        for (int i = 1; i <= 31; i++) send(8'(i));
        check("t3_not_full_31", full0, 0);
        send(8'd32);
        check("t3_full_32", full0, 1);
        check("t3_no_ovf_32", ovf0, 0);
        check("t3_count_16", cnt0, 16);
        send(8'd33);
        check("t3_ovf_33", ovf0, 1);
        check("t3_led_32", led0, 8'h20);
        pulse_run();
        rd(15); check("t3_word15", insn0, 16'h1F20);
        rd(0); check("t3_word0", insn0, 16'h0102);

        // wrap mode, depth 4
        do_reset();
        for (int i = 1; i <= 10; i++) send(8'(i));
        check("t4_ovf", ovf2, 1);
        check("t4_count", cnt2, 1);
        check("t4_full", full2, 0);
        pulse_run();
        rd(0); check("t4_word0", insn2, 16'h090A);
        rd(1); check("t4_word1", insn2, 16'h0304);
        rd(4); check("t4_beyond_depth", insn2, 16'h0000);

        // run beats rx_valid, reload beats run, contents survive reload
        do_reset();
        send(8'h12); send(8'h34);
        run = 1'b1; rx_valid = 1'b1; rx_byte = 8'h99;
        @(negedge clk);
        run = 1'b0; rx_valid = 1'b0;
        check("t5_exec", rm0, 0);
        check("t5_led_kept", led0, 8'h34);
        rd(0); check("t5_word0", insn0, 16'h1234);
        rd(1); check("t5_word1_untouched", insn0, 16'h0000);
        reload = 1'b1; run = 1'b1;
        @(negedge clk);
        reload = 1'b0; run = 1'b0;
        check("t5_reload_mode", rm0, 1);
        check("t5_reload_count", cnt0, 0);
        rd(0); check("t5_load_insn_zero", insn0, 0);
        pulse_run();
        rd(0); check("t5_retained", insn0, 16'h1234);

        // asynchronous reset mid-word
        do_reset();
        send(8'h12); send(8'h34); send(8'h56);
        #2 reset = 1'b0;
        #1;
        check("t6_async_read_mode", rm0, 1);
        check("t6_async_count", cnt0, 0);
        check("t6_async_led", led0, 0);
        check("t6_async_ovf", ovf0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        pulse_run();
        rd(0); check("t6_word0_cleared", insn0, 0);
        rd(1); check("t6_word1_cleared", insn0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_program_memory.md
Name: uart_program_memory

Overview:
- Parametrised program store, loaded byte-by-byte from the UART receive path, then read combinationally by the processor fetch stage.
- Generalises the fixed 16x16 loader in four ways: configurable word width and depth, selectable byte order, full/overflow detection with an optional wrap mode, and a reload command.
- Sits between the top-level UART receiver (which supplies one-cycle byte strobes) and the instruction fetch address.

Parameters:
- WORD_WIDTH, 16, instruction width in bits; must be a multiple of 8, range 8..64.
- DEPTH, 16, number of words; must be at least 2.
- ADDR_WIDTH, 4, fetch/write address width; must satisfy 2^ADDR_WIDTH >= DEPTH.
- MSB_FIRST, 1, 1 = first byte of each word goes into the top lane; 0 = first byte goes into lane 0.
- WRAP, 0, 1 = the write pointer wraps to 0 after the last word; 0 = bytes are dropped once the memory is full.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- run  input  1  enter execute mode.
- reload  input  1  return to load mode without clearing contents.
- rx_valid  input  1  one-cycle strobe: rx_byte is valid this cycle.
- rx_byte  input  8  received byte.
- addr_in  input  ADDR_WIDTH  fetch address.
- insn_out  output  WORD_WIDTH  fetched word.
- read_mode  output  1  high whenever not executing.
- load_count  output  ADDR_WIDTH+1  number of complete words written since the last load start.
- load_full  output  1  the write pointer has reached DEPTH (only when WRAP=0).
- overflow  output  1  sticky; a byte arrived beyond DEPTH words.
- led  output  8  last byte accepted.

Behaviour:
- BPW = WORD_WIDTH/8 bytes per word. Internal registers: write pointer wptr (ADDR_WIDTH+1 bits) and byte counter bcnt (0..BPW-1).
- States: LOAD and EXEC.
- Reset (reset=0, asynchronous):
  - state=LOAD; all memory words, wptr, bcnt, overflow and led clear to 0.
  - Outputs: insn_out=0, read_mode=1, load_count=0, load_full=0.
- LOAD, rx_valid=1, memory not full:
  - Byte is written into word wptr at lane (MSB_FIRST ? BPW-1-bcnt : bcnt); other lanes are unchanged. led<=rx_byte.
  - If bcnt==BPW-1: bcnt<=0 and wptr<=wptr+1. Otherwise bcnt<=bcnt+1.
  - Write latency is one clock: the byte is visible in memory at the following edge.
- Full condition is wptr==DEPTH.
  - WRAP=0: load_full=1; further bytes are ignored (no write, led unchanged); overflow<=1.
  - WRAP=1: on completion of word DEPTH-1, wptr<=0 and overflow<=1; loading continues and overwrites from word 0. load_full stays 0.
- load_count=wptr. With WRAP=1 it returns to 0 after a wrap.
- LOAD, run=1: state<=EXEC.
  - run takes priority over a same-cycle rx_valid; that byte is dropped.
  - A partially received word keeps the bytes already written. Its remaining lanes keep their previous contents (0 after reset).
- EXEC:
  - rx_valid is ignored; run has no further effect.
  - read_mode=0.
  - insn_out = memory[addr_in] combinationally if addr_in<DEPTH, else 0.
- Any state other than EXEC: insn_out=0 and read_mode=1.
- reload=1 (either state): state<=LOAD; wptr, bcnt and overflow <= 0; memory is retained. reload has priority over run and rx_valid in the same cycle.
- Priority order per edge: reset > reload > run > rx_valid.
- Assertion during reset mid-word: everything clears immediately, with no wait for the clock; the partial word is lost.

Test Plan:
- Defaults. Stream bytes 12 34 56 78, then run; addr_in=0 → insn_out=1234; addr_in=1 → 5678; addr_in=2 → 0000; load_count=2 before run.
- MSB_FIRST=0, WORD_WIDTH=24. Bytes AA BB CC, then run; addr_in=0 → CCBBAA. A 4th byte 11 followed by run → word1=000011.
- Defaults, WRAP=0. Send 33 bytes → load_full=1 after byte 32, overflow=1 after byte 33; word15 holds bytes 31..32; led shows byte 32.
- WRAP=1, DEPTH=4. Send 10 bytes 01..0A → word0=090A, word1=0304, overflow=1, load_count=1.
- Run and rx_valid in the same cycle → byte is not written, state=EXEC. Then reload → read_mode=1, load_count=0; the old contents are still readable after the next run.
- Pull reset low mid-word, between clock edges → all outputs are 0 (read_mode=1) before the next posedge; memory reads as 0 after the next run.
